// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmitter.
package i2s_pkg;

  localparam int unsigned SLOT_BITS            = 32;
  localparam int unsigned FRAME_TICKS          = 512;
  localparam int unsigned DEFAULT_SAMPLE_WIDTH = 16;
  localparam int unsigned DEFAULT_MCLK_DIV     = 3;

  // Width of the frame counter t (0..FRAME_TICKS-1).
  localparam int unsigned T_WIDTH = $clog2(FRAME_TICKS);

  // Word-select meaning of i2s_lrck.
  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_ch_e;

endpackage

// File: rtl/i2s_clk_gen.sv
// MCLK divider, 9-bit frame counter and the derived I2S clock outputs.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int unsigned MCLK_DIV = DEFAULT_MCLK_DIV
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  output logic               tick,
  output logic [T_WIDTH-1:0] t,
  output logic               i2s_mclk,
  output logic               i2s_bck,
  output logic               i2s_lrck
);

  localparam logic [7:0] DIV_LAST = 8'(MCLK_DIV - 1);

  logic [7:0]         div_q, div_d;
  logic [T_WIDTH-1:0] t_q, t_d;

  // Divider wraps at MCLK_DIV-1; each wrap advances the frame counter.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 8'd1;
    t_d   = tick ? t_q + T_WIDTH'(1) : t_q;
  end

  // Divider and frame counter state.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_q <= '0;
      t_q   <= '0;
    end else begin
      div_q <= div_d;
      t_q   <= t_d;
    end
  end

  assign t        = t_q;
  assign i2s_mclk = t_q[0];
  assign i2s_bck  = t_q[2];
  assign i2s_lrck = t_q[T_WIDTH-1];

endmodule

// File: rtl/i2s_transmitter.sv
// Philips-format I2S transmitter with a one-pair holding register.
// Optional feature: define I2S_TX_UNDERRUN_CNT_EN to add the 16-bit
// saturating underrun_count output.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int unsigned MCLK_DIV     = DEFAULT_MCLK_DIV,
  parameter int unsigned SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SAMPLE_WIDTH-1:0] s_left,
  input  logic [SAMPLE_WIDTH-1:0] s_right,
  output logic                    i2s_mclk,
  output logic                    i2s_bck,
  output logic                    i2s_lrck,
  output logic                    i2s_dout,
  output logic                    frame_start,
  output logic                    underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]             underrun_count
`endif
);

  localparam logic [4:0] LAST_SLOT = 5'(SAMPLE_WIDTH);

  logic               tick;
  logic [T_WIDTH-1:0] t;
  logic               bit_edge, frame_load, accept, in_sample;
  logic [5:0]         bit_next;
  i2s_ch_e            ch_next;

  logic                    hold_full_q, hold_full_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [SAMPLE_WIDTH-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic                    dout_q, dout_d;
  logic                    fs_q, fs_d;
  logic                    ur_q, ur_d;
  logic                    ready_q, ready_d;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0]             cnt_q, cnt_d;
`endif

  i2s_clk_gen #(
    .MCLK_DIV (MCLK_DIV)
  ) u_clk_gen (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .tick     (tick),
    .t        (t),
    .i2s_mclk (i2s_mclk),
    .i2s_bck  (i2s_bck),
    .i2s_lrck (i2s_lrck)
  );

  // Slot/channel about to start, load and bit-shift decisions, handshake.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    dout_d      = dout_q;
    fs_d        = 1'b0;
    ur_d        = 1'b0;

    bit_edge   = tick && (t[2:0] == 3'b111);
    frame_load = tick && (t == '1);
    accept     = s_valid && ready_q;
    // t[8:3] of the bit period that begins on this BCK falling edge.
    bit_next   = t[T_WIDTH-1:3] + 6'd1;
    ch_next    = i2s_ch_e'(bit_next[5]);
    in_sample  = (bit_next[4:0] != '0) && (bit_next[4:0] <= LAST_SLOT);

    if (bit_edge) begin
      dout_d = 1'b0;
      if (in_sample) begin
        if (ch_next == CH_LEFT) begin
          dout_d    = shift_l_q[SAMPLE_WIDTH-1];
          shift_l_d = shift_l_q << 1;
        end else begin
          dout_d    = shift_r_q[SAMPLE_WIDTH-1];
          shift_r_d = shift_r_q << 1;
        end
      end
    end

    // The wrap tick is also a bit edge, but slot 0 never shifts, so the
    // load below cannot collide with a shift.
    if (frame_load) begin
      fs_d = 1'b1;
      if (hold_full_q) begin
        shift_l_d = hold_l_q;
        shift_r_d = hold_r_q;
      end else begin
        shift_l_d = '0;
        shift_r_d = '0;
        ur_d      = 1'b1;
      end
      hold_full_d = 1'b0;
    end

    // Applied after the load so a pair offered on an empty load cycle is
    // kept for the following frame.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = s_left;
      hold_r_d    = s_right;
    end

    ready_d = !hold_full_d;

`ifdef I2S_TX_UNDERRUN_CNT_EN
    cnt_d = cnt_q;
    if (ur_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
`endif
  end

  // Holding register, shift registers and registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      shift_l_q   <= '0;
      shift_r_q   <= '0;
      dout_q      <= 1'b0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
      ready_q     <= 1'b0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
      cnt_q       <= '0;
`endif
    end else begin
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      dout_q      <= dout_d;
      fs_q        <= fs_d;
      ur_q        <= ur_d;
      ready_q     <= ready_d;
`ifdef I2S_TX_UNDERRUN_CNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign s_ready     = ready_q;
  assign i2s_dout    = dout_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  assign underrun_count = cnt_q;
`endif

endmodule

// File: tb/tb_i2s_transmitter.sv
// Testbench for i2s_transmitter: two instances (MCLK_DIV=3 and MCLK_DIV=1)
// checked cycle by cycle against a frame-level reference model.
module tb_i2s_transmitter;

  localparam int unsigned SW = 16;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic          sys_rst, s_valid;
  logic [SW-1:0] s_left, s_right;

  logic a_ready, a_mclk, a_bck, a_lrck, a_dout, a_fs, a_ur;
  logic b_ready, b_mclk, b_bck, b_lrck, b_dout, b_fs, b_ur;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] a_cnt, b_cnt, o_cnt;
`endif

  i2s_transmitter #(.MCLK_DIV(3), .SAMPLE_WIDTH(SW)) u_dut_div3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .s_valid(s_valid), .s_ready(a_ready),
    .s_left(s_left), .s_right(s_right), .i2s_mclk(a_mclk), .i2s_bck(a_bck),
    .i2s_lrck(a_lrck), .i2s_dout(a_dout), .frame_start(a_fs), .underrun(a_ur)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .underrun_count(a_cnt)
`endif
  );

  i2s_transmitter #(.MCLK_DIV(1), .SAMPLE_WIDTH(SW)) u_dut_div1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .s_valid(s_valid), .s_ready(b_ready),
    .s_left(s_left), .s_right(s_right), .i2s_mclk(b_mclk), .i2s_bck(b_bck),
    .i2s_lrck(b_lrck), .i2s_dout(b_dout), .frame_start(b_fs), .underrun(b_ur)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .underrun_count(b_cnt)
`endif
  );

  // Observed outputs of the instance under test.
  bit   sel;
  logic o_ready, o_mclk, o_bck, o_lrck, o_dout, o_fs, o_ur;
  always_comb begin
    o_ready = sel ? b_ready : a_ready;
    o_mclk  = sel ? b_mclk  : a_mclk;
    o_bck   = sel ? b_bck   : a_bck;
    o_lrck  = sel ? b_lrck  : a_lrck;
    o_dout  = sel ? b_dout  : a_dout;
    o_fs    = sel ? b_fs    : a_fs;
    o_ur    = sel ? b_ur    : a_ur;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    o_cnt   = sel ? b_cnt   : a_cnt;
`endif
  end

  // Reference model state: k = rising edges since reset release,
  // T = MCLK ticks since release = k / D.
  int unsigned   D, k, T, passed, total, ur_seen, fs_k, acc_k, m_urcnt;
  bit            m_ready, m_full, m_fs, m_ur, obs_hs, cap_en;
  logic [SW-1:0] m_hl, m_hr, m_cl, m_cr;
  logic [63:0]   cap;
  logic [63:0]   exp_pattern;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h (k=%0d div=%0d)", tag, obs, exp, k, D);
    end
  endtask

  // Philips I2S bit for tick position tm within a frame.
  function automatic logic exp_dout(input int unsigned tm, input logic [SW-1:0] l,
                                    input logic [SW-1:0] r);
    int unsigned   b, p;
    logic [SW-1:0] s;
    b = tm / 8;
    p = b % 32;
    s = (b >= 32) ? r : l;
    if (p >= 1 && p <= SW) return s[SW-p];
    return 1'b0;
  endfunction

  task automatic check_outputs();
    int unsigned tm;
    tm = (k / D) % 512;
    check("s_ready", o_ready, m_ready);
    check("mclk", o_mclk, tm % 2);
    check("bck", o_bck, (tm / 4) % 2);
    check("lrck", o_lrck, (tm / 256) % 2);
    check("dout", o_dout, exp_dout(tm, m_cl, m_cr));
    check("frame_start", o_fs, m_fs);
    check("underrun", o_ur, m_ur);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("underrun_count", o_cnt, m_urcnt);
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, o_ready, 0);
    check({tag, "_mclk"}, o_mclk, 0);
    check({tag, "_bck"}, o_bck, 0);
    check({tag, "_lrck"}, o_lrck, 0);
    check({tag, "_dout"}, o_dout, 0);
    check({tag, "_frame_start"}, o_fs, 0);
    check({tag, "_underrun"}, o_ur, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check({tag, "_count"}, o_cnt, 0);
`endif
  endtask

  // One sys_clk cycle: advance the model at the rising edge, compare on the falling edge.
  task automatic step();
    bit load, hs;
    obs_hs = s_valid && o_ready;
    @(posedge sys_clk);
    k++;
    T    = k / D;
    load = (k % D == 0) && (T % 512 == 0);
    hs   = s_valid && m_ready;
    m_fs = 1'b0;
    m_ur = 1'b0;
    if (load) begin
      m_fs = 1'b1;
      if (m_full) begin
        m_cl = m_hl;
        m_cr = m_hr;
      end else begin
        m_cl = '0;
        m_cr = '0;
        m_ur = 1'b1;
        if (m_urcnt < 65535) m_urcnt++;
      end
      m_full = 1'b0;
    end
    if (hs) begin
      m_full = 1'b1;
      m_hl   = s_left;
      m_hr   = s_right;
    end
    m_ready = !m_full;
    @(negedge sys_clk);
    check_outputs();
    if (o_ur) ur_seen++;
    if (o_fs) fs_k = k;
    if (cap_en && (k % D == 0) && (T % 8 == 4)) cap = {cap[62:0], o_dout};
  endtask

  task automatic do_reset(input string tag);
    sys_rst = 1'b1;
    s_valid = 1'b0;
    #1;
    check_zero(tag);
    repeat (3) begin
      @(negedge sys_clk);
      check_zero({tag, "_hold"});
    end
    sys_rst = 1'b0;
    k = 0; T = 0; m_ready = 0; m_full = 0; m_fs = 0; m_ur = 0; m_urcnt = 0;
    m_cl = '0; m_cr = '0; m_hl = '0; m_hr = '0; ur_seen = 0; fs_k = 0;
    check_outputs();
  endtask

  task automatic push(input logic [SW-1:0] l, input logic [SW-1:0] r);
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    for (int unsigned i = 0; i < 1100 * D + 4; i++) begin
      step();
      if (obs_hs) break;
    end
    check("push_accepted", obs_hs, 1);
    acc_k   = k;
    s_valid = 1'b0;
  endtask

  task automatic to_frame_start();
    for (int unsigned i = 0; i < 512 * D + 1; i++) begin
      step();
      if ((k % D == 0) && (T % 512 == 0)) break;
    end
  endtask

  task automatic capture_frame();
    cap    = '0;
    cap_en = 1'b1;
    repeat (512 * D) step();
    cap_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    passed = 0; total = 0; cap_en = 0; cap = '0;
    s_valid = 0; s_left = '0; s_right = '0;
    exp_pattern = {1'b0, 16'hA5C3, 15'h0, 1'b0, 16'h8001, 15'h0};

    // ---- MCLK_DIV = 3 ----
    sel = 1'b0; D = 3;
    do_reset("reset");
    step();
    push(16'hA5C3, 16'h8001);
    to_frame_start();
    check("first_load_cycle", fs_k, 1536);
    check("no_underrun_before_first_load", ur_seen, 0);
    capture_frame();
    check("frame_bits_div3", cap, exp_pattern);

    // Frames without pushes: loads into frames 2, 3, 4 all mute.
    repeat (2 * 512 * D) step();
    check("underrun_pulses", ur_seen, 3);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("underrun_count_3", o_cnt, 3);
`endif

    // Back-to-back pairs: second waits for the next frame load.
    push(16'($urandom), 16'($urandom));
    push(16'($urandom), 16'($urandom));
    check("b2b_accept_after_frame_start", acc_k - fs_k, 1);

    // Random traffic with random gaps.
    for (int unsigned i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 400 * D)) step();
      push(16'($urandom), 16'($urandom));
    end

    // Reset in slot p=10 with a pair still pending.
    to_frame_start();
    push(16'($urandom), 16'($urandom));
    for (int unsigned i = 0; i < 512 * D; i++) begin
      if (((T % 512) / 8) == 10) break;
      step();
    end
    do_reset("midframe_reset");
    repeat (512 * D - 1) step();
    check("no_underrun_first_frame_after_reset", ur_seen, 0);
    k = k;
    cap_en = 1'b0;
    step();
    check("pending_discarded_underrun", ur_seen, 1);
    check("first_load_after_reset", fs_k, 512 * D);
    cap = '0;
    capture_frame();
    check("mute_frame_after_reset", cap, 64'h0);

    // ---- MCLK_DIV = 1 ----
    sel = 1'b1; D = 1;
    do_reset("reset_div1");
    step();
    push(16'hA5C3, 16'h8001);
    to_frame_start();
    check("first_load_cycle_div1", fs_k, 512);
    capture_frame();
    check("frame_bits_div1", cap, exp_pattern);
    for (int unsigned i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 300)) step();
      push(16'($urandom), 16'($urandom));
    end
    repeat (600) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2s_transmitter.md
I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 SHALL have parameter MCLK_DIV, default 3: sys_clk cycles per MCLK half-period; legal values 1..255.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 16: audio sample width in bits; legal values 16..31.
REQ-003 sys_clk  in  1  system clock.
REQ-004 sys_rst  in  1  reset; asynchronous, active-high.
REQ-005 s_valid  in  1  sample pair valid.
REQ-006 s_ready  out  1  holding register empty, pair accepted when s_valid && s_ready.
REQ-007 s_left  in  SAMPLE_WIDTH  left sample, two's complement.
REQ-008 s_right  in  SAMPLE_WIDTH  right sample, two's complement.
REQ-009 i2s_mclk  out  1  master clock to DAC.
REQ-010 i2s_bck  out  1  bit clock, MCLK/4.
REQ-011 i2s_lrck  out  1  word select, 0 = left, BCK/64.
REQ-012 i2s_dout  out  1  serial data, changes on BCK falling edge.
REQ-013 frame_start  out  1  one-cycle pulse on frame load.
REQ-014 underrun  out  1  one-cycle pulse when a frame load finds the holding register empty.

Function
REQ-015 A divider counting 0..MCLK_DIV-1 SHALL emit a one-cycle tick at MCLK_DIV-1, then wrap.
REQ-016 A 9-bit frame counter t SHALL increment on every tick and wrap 511->0.
REQ-017 Clock outputs SHALL be registered bits of t: i2s_mclk=t[0], i2s_bck=t[2], i2s_lrck=t[8]; 1 frame = 512*MCLK_DIV sys_clk cycles.
REQ-018 Slot index p=t[7:3] SHALL give Philips I2S timing: p=0 zero, p=1..SAMPLE_WIDTH sample MSB-first, remaining slots zero.
REQ-019 i2s_dout SHALL update only on the tick where t[2:0] goes 7->0, i.e. concurrently with the BCK falling edge.
REQ-020 Frame load SHALL occur on the tick where t wraps 511->0: if the holding register is full, the shift registers SHALL take it, it SHALL be cleared, and frame_start SHALL pulse.
REQ-021 A frame load with the holding register empty SHALL load zeros (mute), and SHALL pulse both frame_start and underrun.
REQ-022 s_ready SHALL equal holding-empty; a handshake on the load cycle while empty SHALL be stored and SHALL be used at the next frame.
REQ-023 When the holding register is full, s_ready SHALL stay 0 until the cycle after frame load.
REQ-024 Sample-to-first-bit latency SHALL be: accepted pair appears at the next frame load; MSB on i2s_dout one BCK period after the load.

Reset
REQ-025 sys_rst SHALL immediately clear the divider, t, the shift registers and the holding register, and SHALL force all outputs to 0 (s_ready included).
REQ-026 After release, the first frame SHALL start at t=0 with zero data and no underrun pulse; reset mid-frame SHALL discard all pending samples.

Configuration
REQ-027 With I2S_TX_UNDERRUN_CNT_EN defined, output underrun_count (16 bits) SHALL be added: incremented on each underrun pulse, saturating at 16'hFFFF, cleared by reset.
REQ-028 Without I2S_TX_UNDERRUN_CNT_EN, underrun_count SHALL not exist; the underrun pulse SHALL be unchanged.

Structure
REQ-029 Package i2s_pkg SHALL hold SLOT_BITS=32, FRAME_TICKS=512, the default SAMPLE_WIDTH and the default MCLK_DIV.
REQ-030 Sub-module i2s_clk_gen SHALL contain the divider, the frame counter and the clock outputs, and SHALL export tick and t.

Verification
REQ-031 MCLK_DIV=3, release reset -> mclk period 6, bck period 24, lrck period 1536 cycles; lrck low first half.
REQ-032 Push L=16'hA5C3, R=16'h8001 in first frame -> next frame: left p1..16 = 1010010111000011, right p1..16 = 1000000000000001, other slots 0.
REQ-033 No pushes for 3 frames -> dout constantly 0, 3 underrun pulses, underrun_count=3 with macro.
REQ-034 Two back-to-back pushes -> first accepted, s_ready=0 until the cycle after frame_start, then second accepted.
REQ-035 sys_rst asserted at slot p=10 -> all outputs 0 same cycle; after release t restarts at 0, first frame zero with no underrun.
REQ-036 MCLK_DIV=1 -> frame 512 cycles, mclk toggles every cycle, data pattern identical to REQ-032.
